// File: rtl/rf_pkg.sv
// Shared register-file write-back definitions: default widths, the hardwired-zero
// register address and the producer request record.
package rf_pkg;

    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 32;
    localparam int RF_ZERO_ADDR = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester at or above
// ptr (wrapping), and reports the winner both one-hot and encoded.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx
);

    logic found;
    int   slot;

    always_comb begin
        // NOTE: every output gets a default before the search loop, so no path
        // leaves a variable unassigned and no latch is inferred.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        slot  = 0;
        for (int k = 0; k < N; k++) begin
            slot = (int'(ptr) + k) % N;
            if (!found && valid[slot]) begin
                grant[slot] = 1'b1;
                idx         = PTR_W'(slot);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing one register-file write port.
// Optional: define RF_ZERO_GUARD_EN to suppress writes to register 0.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = rf_pkg::ADDR_W,
    parameter int DATA_W  = rf_pkg::DATA_W,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rf_write_en,
    output logic [ADDR_W-1:0]          rf_write_address,
    output logic [DATA_W-1:0]          rf_write_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [CNT_W-1:0]           conflict_count
);

    import rf_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] arb_grant;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               accept;
    logic               do_write;
    logic               many_valid;

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Arbitration sees only valid and pointer; reset masks every grant.
    assign req_ready  = rst ? '0 : arb_grant;
    assign accept     = |(req_valid & req_ready);
    assign sel_addr   = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
    assign sel_data   = req_data[int'(arb_idx)*DATA_W +: DATA_W];
    assign next_ptr   = (arb_idx == PTR_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
    assign many_valid = $countones(req_valid) > 1;

`ifdef RF_ZERO_GUARD_EN
    // Writes to register 0 complete the handshake but never reach the file.
    assign do_write = accept && (sel_addr != ADDR_W'(RF_ZERO_ADDR));
`else
    assign do_write = accept;
`endif

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            grant_id <= '0;
        end else if (accept) begin
            rr_ptr   <= next_ptr;
            grant_id <= arb_idx;
        end
    end

    // NOTE: the address/data registers are reset too, because their reset
    // value is observable on the ports; they are not a storage array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_write_en      <= 1'b0;
            rf_write_address <= '0;
            rf_write_data    <= '0;
        end else begin
            rf_write_en <= do_write;
            if (accept) begin
                rf_write_address <= sel_addr;
                rf_write_data    <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_count <= '0;
        end else if (many_valid && (conflict_count != '1)) begin
            conflict_count <= conflict_count + 1'b1;
        end
    end

endmodule
